// File: rtl/riscboy_ppu_lcd_seq.sv
// riscboy_ppu_lcd_seq: hardware LCD window-update sequencer.
// Define PPU_LCD_SEQ_ABORT_EN to add the i_abort / o_aborted port pair.
module riscboy_ppu_lcd_seq #(
    parameter int W_PXDATA     = 16,
    parameter int W_COORD      = 9,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [W_COORD-1:0]  i_x0,
    input  logic [W_COORD-1:0]  i_x1,
    input  logic [W_COORD-1:0]  i_y0,
    input  logic [W_COORD-1:0]  i_y1,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_px_vld,
    output logic                o_px_rdy,
    input  logic [W_PXDATA-1:0] i_px_data,
    output logic [W_PXDATA-1:0] o_pxfifo_wdata,
    output logic                o_pxfifo_wen,
    input  logic                i_pxfifo_wfull,
    input  logic                i_pxfifo_wempty,
    input  logic                i_lcd_tx_busy,
    output logic                o_lcd_cs,
    output logic                o_lcd_dc,
    output logic [4:0]          o_lcd_shamt
`ifdef PPU_LCD_SEQ_ABORT_EN
    ,
    input  logic                i_abort,
    output logic                o_aborted
`endif
);

    localparam int W_CNT  = 2 * W_COORD + 1;
    localparam int W_DCNT = $clog2(DRAIN_CYCLES + 1);
    localparam logic [W_DCNT-1:0] DCNT_LAST = W_DCNT'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_CMD, S_ARG0, S_ARG1, S_STREAM, S_FINISH
    } state_t;

    state_t             r_state, w_nstate, r_tgt, w_tgt;
    logic [1:0]         r_step;
    logic [W_COORD-1:0] r_x0, r_x1, r_y0, r_y1;
    logic [W_CNT-1:0]   r_cnt, w_n;
    logic [W_DCNT-1:0]  r_dcnt;
    logic               r_pcs, r_pdc, w_pcs, w_pdc;
    logic [4:0]         r_psh, w_psh;
    logic               r_cs, r_dc, r_busy, r_done, r_err;
    logic [4:0]         r_shamt;
    logic               w_abort, w_abort_act, w_idle, w_legal;
    logic               w_drain_hit, w_hs, w_push;
    logic [7:0]         w_cmd;
    logic [W_COORD:0]   w_dx, w_dy;

`ifdef PPU_LCD_SEQ_ABORT_EN
    logic r_abt, r_aborted;
    assign w_abort   = i_abort;
    assign o_aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign w_abort_act = w_abort && (r_state != S_IDLE) && (r_state != S_FINISH);
    assign w_idle      = i_pxfifo_wempty && !i_lcd_tx_busy;
    assign w_legal     = (i_x1 >= i_x0) && (i_y1 >= i_y0);
    assign w_drain_hit = (r_state == S_DRAIN) && w_idle && (r_dcnt == DCNT_LAST);
    assign w_hs        = (r_state == S_STREAM) && i_px_vld && !i_pxfifo_wfull;
    assign w_dx        = {1'b0, i_x1} - {1'b0, i_x0} + (W_COORD + 1)'(1);
    assign w_dy        = {1'b0, i_y1} - {1'b0, i_y0} + (W_COORD + 1)'(1);
    assign w_n         = W_CNT'(w_dx) * W_CNT'(w_dy);
    assign w_cmd       = (r_step == 2'd0) ? 8'h2A : (r_step == 2'd1) ? 8'h2B : 8'h2C;

    // An abort seen while draining overrides the pending target and leaves the pins alone
    assign w_tgt = w_abort ? S_FINISH : r_tgt;
    assign w_pcs = w_abort ? r_cs : r_pcs;
    assign w_pdc = w_abort ? r_dc : r_pdc;
    assign w_psh = w_abort ? r_shamt : r_psh;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_nstate;
    end

    // Next-state logic
    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start && w_legal) w_nstate = S_DRAIN;
            S_DRAIN:  if (w_drain_hit) w_nstate = w_tgt;
            S_CMD:    if (w_abort || !i_pxfifo_wfull) w_nstate = S_DRAIN;
            S_ARG0: begin
                if (w_abort)              w_nstate = S_DRAIN;
                else if (!i_pxfifo_wfull) w_nstate = S_ARG1;
            end
            S_ARG1:   if (w_abort || !i_pxfifo_wfull) w_nstate = S_DRAIN;
            S_STREAM: begin
                if (w_abort)                                w_nstate = S_DRAIN;
                else if (w_hs && r_cnt == W_CNT'(1)) w_nstate = S_DRAIN;
            end
            S_FINISH: w_nstate = S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    // FIFO write data and renderer handshake for the current state
    always_comb begin
        w_push         = 1'b0;
        o_pxfifo_wdata = '0;
        o_px_rdy       = 1'b0;
        unique case (r_state)
            S_CMD: begin
                w_push         = !w_abort;
                o_pxfifo_wdata = W_PXDATA'({w_cmd, 8'h00});
            end
            S_ARG0: begin
                w_push         = !w_abort;
                o_pxfifo_wdata = W_PXDATA'(r_step[0] ? r_y0 : r_x0);
            end
            S_ARG1: begin
                w_push         = !w_abort;
                o_pxfifo_wdata = W_PXDATA'(r_step[0] ? r_y1 : r_x1);
            end
            S_STREAM: begin
                w_push         = !w_abort && i_px_vld;
                o_pxfifo_wdata = i_px_data;
                o_px_rdy       = !i_pxfifo_wfull;
            end
            default: ;
        endcase
    end

    assign o_pxfifo_wen = w_push && !i_pxfifo_wfull;

    // Transaction context, drain counter and registered pin/status outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cs    <= 1'b1;
            r_dc    <= 1'b0;
            r_shamt <= 5'd16;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tgt   <= S_CMD;
            r_step  <= 2'd0;
            r_dcnt  <= '0;
            r_pcs   <= 1'b1;
            r_pdc   <= 1'b0;
            r_psh   <= 5'd16;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state != S_DRAIN) r_dcnt <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start && w_legal) begin
                        r_x0   <= i_x0;
                        r_x1   <= i_x1;
                        r_y0   <= i_y0;
                        r_y1   <= i_y1;
                        r_cnt  <= w_n;
                        r_step <= 2'd0;
                        r_busy <= 1'b1;
                        r_tgt  <= S_CMD;
                        r_pcs  <= 1'b0;
                        r_pdc  <= 1'b0;
                        r_psh  <= 5'd8;
                    end else if (i_start) begin
                        r_err <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!w_idle)           r_dcnt <= '0;
                    else if (!w_drain_hit) r_dcnt <= r_dcnt + W_DCNT'(1);
                    if (w_drain_hit) begin
                        r_cs    <= w_pcs;
                        r_dc    <= w_pdc;
                        r_shamt <= w_psh;
                    end
                end
                S_CMD: begin
                    if (!i_pxfifo_wfull) begin
                        r_tgt <= (r_step == 2'd2) ? S_STREAM : S_ARG0;
                        r_pcs <= 1'b0;
                        r_pdc <= 1'b1;
                        r_psh <= 5'd16;
                    end
                end
                S_ARG1: begin
                    if (!i_pxfifo_wfull) begin
                        r_tgt  <= S_CMD;
                        r_step <= r_step + 2'd1;
                        r_pcs  <= 1'b0;
                        r_pdc  <= 1'b0;
                        r_psh  <= 5'd8;
                    end
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt - W_CNT'(1);
                        if (r_cnt == W_CNT'(1)) begin
                            r_tgt <= S_FINISH;
                            r_pcs <= r_cs;
                            r_pdc <= r_dc;
                            r_psh <= r_shamt;
                        end
                    end
                end
                S_FINISH: begin
                    r_cs   <= 1'b1;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
            if (w_abort_act) begin
                r_tgt <= S_FINISH;
                r_pcs <= r_cs;
                r_pdc <= r_dc;
                r_psh <= r_shamt;
            end
        end
    end

`ifdef PPU_LCD_SEQ_ABORT_EN
    // Remember whether the running transaction was cut short
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_abt     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (r_state == S_IDLE) r_abt <= 1'b0;
            else if (w_abort_act)  r_abt <= 1'b1;
            if (r_state == S_FINISH) r_aborted <= r_abt;
        end
    end
`endif

    assign o_lcd_cs    = r_cs;
    assign o_lcd_dc    = r_dc;
    assign o_lcd_shamt = r_shamt;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
